// File: rtl/mux_sel_pkg.sv
// Shared constants and state encoding for the mux select arbiter.
// Optional stall statistics are enabled with MUX_SEL_STATS_EN.
package mux_sel_pkg;
    localparam int NUM_SRC = 4;
    localparam int SEL_W   = 2;
    localparam int BEAT_W  = 4;

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;
endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_gnt, wrapping.
module rr_pick
    import mux_sel_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   last_gnt,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);
    logic [SEL_W-1:0] cand;

    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        // Offsets 1..NUM_SRC; the final offset wraps back to last_gnt itself.
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = last_gnt + SEL_W'(k);
            if (!any && req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin packet arbiter driving the 4:1 mux SEL with a VALID/READY handshake.
// Define MUX_SEL_STATS_EN to add the saturating STALL_CNT output.
module mux_sel_arbiter
    import mux_sel_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_SRC-1:0] REQ,
    input  logic [NUM_SRC-1:0] LAST,
    input  logic               READY,
    output logic [SEL_W-1:0]   SEL,
    output logic [NUM_SRC-1:0] GNT,
    output logic               VALID
`ifdef MUX_SEL_STATS_EN
    ,
    output logic [7:0]         STALL_CNT
`endif
);
    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_SRC-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;

    logic [SEL_W-1:0]   pick_idx;
    logic               pick_any;
    logic               xfer;
    logic               burst_end;

    rr_pick u_pick (
        .req      (REQ),
        .last_gnt (last_q),
        .idx      (pick_idx),
        .any      (pick_any)
    );

    assign VALID     = (state_q == GRANT) && REQ[sel_q];
    assign xfer      = VALID && READY;
    assign burst_end = (beat_q == BEAT_W'(MAX_BURST - 1));
    assign SEL       = sel_q;
    assign GNT       = gnt_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    gnt_d   = NUM_SRC'(1) << pick_idx;
                    last_d  = pick_idx;
                    beat_d  = '0;
                end
            end
            GRANT: begin
                if (!REQ[sel_q] || (xfer && (LAST[sel_q] || burst_end))) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    beat_d  = '0;
                end else if (xfer) begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            last_q  <= SEL_W'(NUM_SRC - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

`ifdef MUX_SEL_STATS_EN
    logic [7:0] stall_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q <= '0;
        end else if (VALID && !READY && (stall_q != 8'hFF)) begin
            stall_q <= stall_q + 8'd1;
        end
    end

    assign STALL_CNT = stall_q;
`endif
endmodule
